// File: rtl/morse_key_decoder.sv
// Morse key decoder: times key presses/releases in ms ticks, builds a dot/dash code, emits it on a letter gap.
// Latency: key edge acts 3 clocks after key_in moves; pulses are registered. No backpressure; pulses are fire-and-forget.
module morse_key_decoder #(
    parameter int DASH_MS       = 300,
    parameter int LETTER_GAP_MS = 700,
    parameter int MAX_PRESS_MS  = 2000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       ms_tick,
    input  logic       key_in,
    output logic [4:0] code_out,
    output logic [2:0] len_out,
    output logic       letter_valid,
    output logic       error
);

    localparam logic [11:0] DASH_T = 12'(DASH_MS);
    localparam logic [11:0] GAP_T  = 12'(LETTER_GAP_MS);
    localparam logic [11:0] MAX_T  = 12'(MAX_PRESS_MS);

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        GAP,
        WAIT_RELEASE
    } state_t;

    state_t      state_q, state_d;
    logic        key_meta_q, key_s_q, key_prev_q;
    logic [11:0] cnt_q, cnt_d, cnt_tick;
    logic [4:0]  buf_q, buf_d;
    logic [2:0]  nsym_q, nsym_d;
    logic [4:0]  code_q, code_d;
    logic [2:0]  len_q, len_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic        press_edge, release_edge, sym;

    assign press_edge   = key_s_q & ~key_prev_q;
    assign release_edge = ~key_s_q & key_prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_meta_q <= 1'b0;
            key_s_q    <= 1'b0;
            key_prev_q <= 1'b0;
        end else begin
            key_meta_q <= key_in;
            key_s_q    <= key_meta_q;
            key_prev_q <= key_s_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            buf_q   <= '0;
            nsym_q  <= '0;
            code_q  <= '0;
            len_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            nsym_q  <= nsym_d;
            code_q  <= code_d;
            len_q   <= len_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // Saturating post-increment count; all thresholds compare against this value.
    always_comb begin
        cnt_tick = cnt_q;
        if (ms_tick && (cnt_q != 12'hFFF)) begin
            cnt_tick = cnt_q + 12'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        nsym_d  = nsym_q;
        code_d  = code_q;
        len_d   = len_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        sym     = 1'b0;

        case (state_q)
            IDLE: begin
                buf_d  = '0;
                nsym_d = '0;
                if (press_edge) begin
                    state_d = PRESS;
                end
            end
            PRESS: begin
                if (cnt_tick >= MAX_T) begin
                    err_d   = 1'b1;
                    buf_d   = '0;
                    nsym_d  = '0;
                    state_d = WAIT_RELEASE;
                end else if (release_edge) begin
                    sym = (cnt_tick >= DASH_T);
                    if (nsym_q == 3'd5) begin
                        err_d   = 1'b1;
                        buf_d   = '0;
                        nsym_d  = '0;
                        state_d = IDLE;
                    end else begin
                        buf_d   = {buf_q[3:0], sym};
                        nsym_d  = nsym_q + 3'd1;
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                // A press landing on the expiry cycle completes this letter and starts the next one.
                if (cnt_tick >= GAP_T) begin
                    code_d  = buf_q;
                    len_d   = nsym_q;
                    valid_d = 1'b1;
                    buf_d   = '0;
                    nsym_d  = '0;
                    state_d = press_edge ? PRESS : IDLE;
                end else if (press_edge) begin
                    state_d = PRESS;
                end
            end
            WAIT_RELEASE: begin
                if (!key_s_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (!enable) begin
            state_d = IDLE;
            buf_d   = '0;
            nsym_d  = '0;
            code_d  = code_q;
            len_d   = len_q;
            valid_d = 1'b0;
            err_d   = 1'b0;
        end
    end

    always_comb begin
        cnt_d = '0;
        if (enable && (state_d == state_q) && ((state_q == PRESS) || (state_q == GAP))) begin
            cnt_d = cnt_tick;
        end
    end

    assign code_out     = code_q;
    assign len_out      = len_q;
    assign letter_valid = valid_q;
    assign error        = err_q;

endmodule

// File: tb/tb_morse_key_decoder.sv
// Directed bench for morse_key_decoder with DASH=3, GAP=7, MAX=20 ticks and a tick every 4 clocks.
module tb_morse_key_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       ms_tick;
    logic       key_in;
    logic [4:0] code_out;
    logic [2:0] len_out;
    logic       letter_valid;
    logic       error;

    int n_vec  = 0;
    int n_bad  = 0;
    int n_valid = 0;
    int n_err  = 0;
    int n_both = 0;
    int tick_ph = 0;

    morse_key_decoder #(
        .DASH_MS(3),
        .LETTER_GAP_MS(7),
        .MAX_PRESS_MS(20)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .ms_tick(ms_tick),
        .key_in(key_in),
        .code_out(code_out),
        .len_out(len_out),
        .letter_valid(letter_valid),
        .error(error)
    );

    initial forever #5 clk = ~clk;

    initial begin
        ms_tick = 1'b0;
        forever begin
            @(negedge clk);
            tick_ph = (tick_ph + 1) % 4;
            ms_tick = (tick_ph == 0);
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (letter_valid === 1'b1) n_valid++;
        if (error === 1'b1) n_err++;
        if (letter_valid === 1'b1 && error === 1'b1) n_both++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Leaves the bench just after the negedge whose ms_tick is sampled at the next posedge.
    task automatic sync_tick();
        do begin
            @(negedge clk);
            #1;
        end while (ms_tick !== 1'b1);
    endtask

    task automatic press(input int n);
        key_in = 1'b1;
        repeat (4 * n) @(negedge clk);
        key_in = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (4 * n) @(negedge clk);
    endtask

    task automatic wait_pulse(input bit want_err, output int cyc, output bit seen);
        cyc  = 0;
        seen = 1'b0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
            seen = want_err ? (error === 1'b1) : (letter_valid === 1'b1);
        end while (!seen && cyc < 200);
    endtask

    initial begin
        int  cyc;
        bit  seen;
        int  v0, e0;

        rst    = 1'b1;
        enable = 1'b1;
        key_in = 1'b0;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_code", code_out, 0);
        check("rst_len", len_out, 0);
        check("rst_valid", letter_valid, 0);
        check("rst_error", error, 0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // Letter A: dot then dash
        sync_tick();
        press(1);
        gap(2);
        press(4);
        wait_pulse(1'b0, cyc, seen);
        check("A_seen", seen, 1);
        check("A_latency", cyc, 29);
        check("A_code", code_out, 5'b00001);
        check("A_len", len_out, 2);
        gap(10);
        check("A_held_code", code_out, 5'b00001);
        check("A_held_len", len_out, 2);
        check("A_pulses", n_valid, 1);

        // Reset in the middle of a letter
        sync_tick();
        press(1);
        gap(1);
        key_in = 1'b1;
        repeat (8) @(negedge clk);
        rst    = 1'b0;
        key_in = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_code", code_out, 0);
        check("midrst_len", len_out, 0);
        check("midrst_valid", letter_valid, 0);
        check("midrst_error", error, 0);
        rst = 1'b1;
        gap(10);
        check("midrst_no_letter", n_valid, 1);
        check("midrst_no_error", n_err, 0);

        // Dot/dash boundary
        sync_tick();
        press(2);
        wait_pulse(1'b0, cyc, seen);
        check("dot2_latency", cyc, 29);
        check("dot2_code", code_out, 0);
        check("dot2_len", len_out, 1);
        sync_tick();
        press(3);
        wait_pulse(1'b0, cyc, seen);
        check("dash3_latency", cyc, 29);
        check("dash3_code", code_out, 1);
        check("dash3_len", len_out, 1);

        // Five dashes, then a six-symbol overflow
        sync_tick();
        for (int i = 0; i < 4; i++) begin
            press(3);
            gap(1);
        end
        press(3);
        wait_pulse(1'b0, cyc, seen);
        check("five_seen", seen, 1);
        check("five_code", code_out, 5'b11111);
        check("five_len", len_out, 5);
        v0 = n_valid;
        e0 = n_err;
        sync_tick();
        for (int i = 0; i < 5; i++) begin
            press(3);
            gap(1);
        end
        press(3);
        wait_pulse(1'b1, cyc, seen);
        check("ovf_err_latency", cyc, 3);
        gap(12);
        check("ovf_err_count", n_err - e0, 1);
        check("ovf_no_letter", n_valid - v0, 0);
        check("ovf_held_code", code_out, 5'b11111);
        check("ovf_held_len", len_out, 5);

        // enable dropped during an intra-letter gap
        v0 = n_valid;
        e0 = n_err;
        sync_tick();
        press(1);
        gap(2);
        enable = 1'b0;
        gap(10);
        enable = 1'b1;
        gap(10);
        check("en_no_letter", n_valid - v0, 0);
        check("en_no_error", n_err - e0, 0);
        check("en_kept_code", code_out, 5'b11111);
        check("en_kept_len", len_out, 5);
        sync_tick();
        press(3);
        wait_pulse(1'b0, cyc, seen);
        check("en_after_code", code_out, 1);
        check("en_after_len", len_out, 1);

        // Stuck key
        v0 = n_valid;
        e0 = n_err;
        sync_tick();
        key_in = 1'b1;
        wait_pulse(1'b1, cyc, seen);
        check("stuck_err_latency", cyc, 81);
        gap(10);
        check("stuck_err_once", n_err - e0, 1);
        check("stuck_no_letter", n_valid - v0, 0);
        key_in = 1'b0;
        gap(2);
        sync_tick();
        press(1);
        wait_pulse(1'b0, cyc, seen);
        check("stuck_after_latency", cyc, 29);
        check("stuck_after_code", code_out, 0);
        check("stuck_after_len", len_out, 1);

        // Press edge lands on the 7th gap tick
        v0 = n_valid;
        sync_tick();
        press(3);
        repeat (26) @(negedge clk);
        key_in = 1'b1;
        wait_pulse(1'b0, cyc, seen);
        check("coll_first_latency", cyc, 3);
        check("coll_first_code", code_out, 1);
        check("coll_first_len", len_out, 1);
        repeat (2) @(negedge clk);
        key_in = 1'b0;
        wait_pulse(1'b0, cyc, seen);
        check("coll_second_latency", cyc, 31);
        check("coll_second_code", code_out, 0);
        check("coll_second_len", len_out, 1);
        gap(10);
        check("coll_letters", n_valid - v0, 2);

        check("never_both", n_both, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
